edge_event_arbiter: RTL and testbench

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

---
 rtl/edge_event_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_edge_event_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter
//
// Detects edges on NUM_CH synchronous level inputs, queues one pending event
// per slot, and presents the events one at a time on a valid/ready port.
// Slots are picked round-robin. The search starts one past the last granted
// slot.
// A second edge on a slot that is still pending is dropped and flagged in a
// sticky per-channel overrun bit. Accepted events are counted in a wrapping
// counter.
//
// Optional feature macro: EDGE_ARB_FALLING_EN
//   defined   : two slots per channel (rise, fall), order ch0R, ch0F, ch1R...
//               and falling events present with evt_pol = 0.
//   undefined : falling edges ignored, one slot per channel, evt_pol = 1.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   level      in   [NUM_CH]  per-channel level signals (synchronous to clk)
//   evt_valid  out  event presented
//   evt_ready  in   consumer accepts the presented event
//   evt_ch     out  [$clog2(NUM_CH)]  channel of presented event
//   evt_pol    out  1 = rising, 0 = falling
//   ovf        out  [NUM_CH]  sticky overrun flags
//   ovf_clr    in   clear all overrun flags
//   evt_cnt    out  [CNT_W]   accepted-event count (wraps)
// ---------------------------------------------------------------------------
module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         level,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(NUM_CH)-1:0] evt_ch,
  output logic                      evt_pol,
  output logic [NUM_CH-1:0]         ovf,
  input  logic                      ovf_clr,
  output logic [CNT_W-1:0]          evt_cnt
);

  localparam int CW = $clog2(NUM_CH);
`ifdef EDGE_ARB_FALLING_EN
  localparam int NS = 2 * NUM_CH;
`else
  localparam int NS = NUM_CH;
`endif
  localparam int SW = $clog2(NS);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NS - 1);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] level_q;
  logic [NS-1:0]     pending_q, pending_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [CW-1:0]     evt_ch_q, evt_ch_d;
  logic [CNT_W-1:0]  evt_cnt_q, evt_cnt_d;
  logic [SW-1:0]     last_grant_q, last_grant_d;

  logic [NUM_CH-1:0] rise;
  logic [NS-1:0]     slot_edge;
  logic [NS-1:0]     ovf_slot;
  logic [NUM_CH-1:0] ovf_set;
  logic [NS-1:0]     clr;
  logic              load;
  logic              hs;
  logic              win_found;
  logic [SW-1:0]     win_slot;
  logic [CW-1:0]     win_ch;
  logic              win_pol;

  assign rise = level & ~level_q;

`ifdef EDGE_ARB_FALLING_EN
  logic [NUM_CH-1:0] fall;
  logic              evt_pol_q, evt_pol_d;
  assign fall = ~level & level_q;

  // Interleave rise/fall per channel so arbitration order is ch0R, ch0F, ...
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
    assign slot_edge[2*gi]   = rise[gi];
    assign slot_edge[2*gi+1] = fall[gi];
    assign ovf_set[gi]       = ovf_slot[2*gi] | ovf_slot[2*gi+1];
  end
  assign win_ch  = win_slot[SW-1:1];
  assign win_pol = ~win_slot[0];
  assign evt_pol = evt_pol_q;
`else
  assign slot_edge = rise;
  assign ovf_set   = ovf_slot;
  assign win_ch    = win_slot;
  assign win_pol   = 1'b1;
  assign evt_pol   = 1'b1;
`endif

  // Round-robin: first pending slot found from last_grant+1 upward, wrapping.
  always_comb begin
    logic [SW:0] idx;
    win_found = 1'b0;
    win_slot  = '0;
    idx       = '0;
    for (int off = 1; off <= NS; off++) begin
      idx = {1'b0, last_grant_q} + (SW+1)'(off);
      if (idx >= (SW+1)'(NS)) idx = idx - (SW+1)'(NS);
      if (!win_found && pending_q[idx[SW-1:0]]) begin
        win_found = 1'b1;
        win_slot  = idx[SW-1:0];
      end
    end
  end

  assign evt_valid = (state_q == PRESENT);
  assign hs        = evt_valid & evt_ready;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (evt_ready) begin
          if (win_found) load = 1'b1;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr = '0;
    if (load) clr[win_slot] = 1'b1;
    // A slot being loaded this cycle is free again, so a fresh edge on it
    // re-pends rather than overflowing.
    ovf_slot     = slot_edge & pending_q & ~clr;
    pending_d    = (pending_q & ~clr) | slot_edge;
    // Set has priority over clear so no overrun can be lost to ovf_clr.
    ovf_d        = (ovf_clr ? '0 : ovf_q) | ovf_set;
    evt_ch_d     = load ? win_ch : evt_ch_q;
    last_grant_d = load ? win_slot : last_grant_q;
    evt_cnt_d    = hs ? evt_cnt_q + 1'b1 : evt_cnt_q;
`ifdef EDGE_ARB_FALLING_EN
    evt_pol_d    = load ? win_pol : evt_pol_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      level_q      <= '0;
      pending_q    <= '0;
      ovf_q        <= '0;
      evt_ch_q     <= '0;
      evt_cnt_q    <= '0;
      last_grant_q <= LAST_SLOT;
`ifdef EDGE_ARB_FALLING_EN
      evt_pol_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      level_q      <= level;
      pending_q    <= pending_d;
      ovf_q        <= ovf_d;
      evt_ch_q     <= evt_ch_d;
      evt_cnt_q    <= evt_cnt_d;
      last_grant_q <= last_grant_d;
`ifdef EDGE_ARB_FALLING_EN
      evt_pol_q    <= evt_pol_d;
`endif
    end
  end

  assign evt_ch  = evt_ch_q;
  assign ovf     = ovf_q;
  assign evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (NUM_CH=4, CNT_W=3 so the counter
// wrap is reachable in a few events). Inputs change 1 time unit after a
// rising clock edge; outputs are sampled at the same point.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] level = 4'b0000;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_ch;
  logic       evt_pol;
  logic [3:0] ovf;
  logic       ovf_clr = 1'b0;
  logic [2:0] evt_cnt;

  int checks = 0;
  int errors = 0;

  edge_event_arbiter #(.NUM_CH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .level(level), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_ch(evt_ch), .evt_pol(evt_pol),
    .ovf(ovf), .ovf_clr(ovf_clr), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; level = 4'b0000; ovf_clr = 1'b0; evt_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
    checks++; if (evt_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d want 0", evt_ch); end
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL reset_ovf: got %b want 0000", ovf); end
    checks++; if (evt_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", evt_cnt); end
    // Level held high through reset gives a rising event after release.
    level = 4'b0001;
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rel_early_valid: got %b want 0", evt_valid); end
    step();
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_pol !== 1'b1) begin errors++; $display("FAIL rel_event: got v%b ch%0d p%b want v1 ch0 p1", evt_valid, evt_ch, evt_pol); end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    do_reset();
    evt_ready = 1'b1;
    level = 4'b0001;
    step();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_c1_valid: got %b want 0", evt_valid); end
    step();
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_pol !== 1'b1) begin errors++; $display("FAIL single_event: got v%b ch%0d p%b want v1 ch0 p1", evt_valid, evt_ch, evt_pol); end
    step();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_c3_valid: got %b want 0", evt_valid); end
    checks++; if (evt_cnt !== 3'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", evt_cnt); end
    $display("test_single: ch0 event accepted");
  endtask

  task automatic test_back_to_back();
    do_reset();
    evt_ready = 1'b1;
    level = 4'b1111;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'(i)) begin errors++; $display("FAIL b2b_ev%0d: got v%b ch%0d want v1 ch%0d", i, evt_valid, evt_ch, i); end
    end
    step();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", evt_valid); end
    checks++; if (evt_cnt !== 3'd4) begin errors++; $display("FAIL b2b_cnt: got %0d want 4", evt_cnt); end
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL b2b_ovf: got %b want 0000", ovf); end
    $display("test_back_to_back: 4 events");
  endtask

  task automatic test_overflow();
    do_reset();
    level = 4'b0100; step();
    level = 4'b0000; step();
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd2) begin errors++; $display("FAIL ovf_first: got v%b ch%0d want v1 ch2", evt_valid, evt_ch); end
    level = 4'b0100; step();
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL ovf_second_rise: got %b want 0000", ovf); end
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd2) begin errors++; $display("FAIL ovf_hold1: got v%b ch%0d want v1 ch2", evt_valid, evt_ch); end
    level = 4'b0000; step();
    level = 4'b0100; step();
    checks++; if (ovf !== 4'b0100) begin errors++; $display("FAIL ovf_set: got %b want 0100", ovf); end
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_pol !== 1'b1) begin errors++; $display("FAIL ovf_hold2: got v%b ch%0d p%b want v1 ch2 p1", evt_valid, evt_ch, evt_pol); end
    ovf_clr = 1'b1; step();
    ovf_clr = 1'b0;
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL ovf_clr: got %b want 0000", ovf); end
    level = 4'b0000; step();
    level = 4'b0100; ovf_clr = 1'b1; step();
    ovf_clr = 1'b0;
    checks++; if (ovf !== 4'b0100) begin errors++; $display("FAIL ovf_vs_clr: got %b want 0100", ovf); end
    checks++; if (evt_cnt !== 3'd0) begin errors++; $display("FAIL ovf_cnt: got %0d want 0", evt_cnt); end
    $display("test_overflow: done");
  endtask

  task automatic test_pend_on_load();
    do_reset();
    evt_ready = 1'b1;
    level = 4'b0011; step();
    level = 4'b0001; step();
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin errors++; $display("FAIL pol_ev0: got v%b ch%0d want v1 ch0", evt_valid, evt_ch); end
    level = 4'b0011; step();
    checks++; if (evt_ch !== 2'd1 || evt_pol !== 1'b1) begin errors++; $display("FAIL pol_ev1: got ch%0d p%b want ch1 p1", evt_ch, evt_pol); end
    step();
`ifdef EDGE_ARB_FALLING_EN
    checks++; if (evt_ch !== 2'd1 || evt_pol !== 1'b0) begin errors++; $display("FAIL pol_ev2: got ch%0d p%b want ch1 p0", evt_ch, evt_pol); end
    step();
`endif
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_pol !== 1'b1) begin errors++; $display("FAIL pol_repend: got v%b ch%0d p%b want v1 ch1 p1", evt_valid, evt_ch, evt_pol); end
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL pol_ovf: got %b want 0000", ovf); end
    $display("test_pend_on_load: done");
  endtask

  task automatic test_round_robin();
    do_reset();
    evt_ready = 1'b1;
    level = 4'b0010; step(); step();
    checks++; if (evt_ch !== 2'd1) begin errors++; $display("FAIL rr_grant1: got ch%0d want ch1", evt_ch); end
    step();
    level = 4'b1011; step(); step();
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd3) begin errors++; $display("FAIL rr_first: got v%b ch%0d want v1 ch3", evt_valid, evt_ch); end
    step();
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin errors++; $display("FAIL rr_second: got v%b ch%0d want v1 ch0", evt_valid, evt_ch); end
    $display("test_round_robin: ch3 before ch0");
  endtask

  task automatic test_falling();
    do_reset();
    evt_ready = 1'b1;
    level = 4'b0010; step();
    level = 4'b0000; step();
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_pol !== 1'b1) begin errors++; $display("FAIL fall_rise: got v%b ch%0d p%b want v1 ch1 p1", evt_valid, evt_ch, evt_pol); end
    step();
`ifdef EDGE_ARB_FALLING_EN
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_pol !== 1'b0) begin errors++; $display("FAIL fall_fall: got v%b ch%0d p%b want v1 ch1 p0", evt_valid, evt_ch, evt_pol); end
    step();
    checks++; if (evt_cnt !== 3'd2) begin errors++; $display("FAIL fall_cnt: got %0d want 2", evt_cnt); end
`else
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL fall_ignored: got %b want 0", evt_valid); end
    checks++; if (evt_cnt !== 3'd1) begin errors++; $display("FAIL fall_cnt: got %0d want 1", evt_cnt); end
`endif
    $display("test_falling: done");
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    evt_ready = 1'b1;
    level = 4'b1111; for (int i = 0; i < 6; i++) step();
    level = 4'b0000; for (int i = 0; i < 6; i++) step();
    level = 4'b1111; for (int i = 0; i < 6; i++) step();
`ifdef EDGE_ARB_FALLING_EN
    checks++; if (evt_cnt !== 3'd4) begin errors++; $display("FAIL cnt_wrap: got %0d want 4", evt_cnt); end
`else
    checks++; if (evt_cnt !== 3'd0) begin errors++; $display("FAIL cnt_wrap: got %0d want 0", evt_cnt); end
`endif
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL cnt_idle: got %b want 0", evt_valid); end
    $display("test_cnt_wrap: done");
  endtask

  task automatic test_reset_in_present();
    do_reset();
    level = 4'b0111; step(); step();
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin errors++; $display("FAIL rip_present: got v%b ch%0d want v1 ch0", evt_valid, evt_ch); end
    #2;
    rst = 1'b1; level = 4'b0000;
    #1;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rip_async: got %b want 0", evt_valid); end
    step(); step();
    rst = 1'b0; evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rip_quiet%0d: got %b want 0", i, evt_valid); end
    end
    checks++; if (evt_cnt !== 3'd0 || ovf !== 4'b0000) begin errors++; $display("FAIL rip_state: got cnt%0d ovf%b want cnt0 ovf0000", evt_cnt, ovf); end
    $display("test_reset_in_present: done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_pend_on_load();
    test_round_robin();
    test_falling();
    test_cnt_wrap();
    test_reset_in_present();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
